tdc_ctrl: RTL

Sequencer for the trigger-interpolation TDC in the DSO acquisition path. Clears and arms the TDC front end, waits for the synchronized widened-pulse flag, lets the pulse-width counter settle, then double-samples and range-checks the count. The result goes to the acquisition controller over a valid/ready handshake with an error code. Single-shot or continuous re-arm.

---
 rtl/tdc_ctrl_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/tdc_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tdc_ctrl_pkg.sv
// Shared types and codes for the trigger-interpolation TDC sequencer.
package tdc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_CHECK  = 3'd5,
    ST_OUT    = 3'd6
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_UNSTABLE = 2'b10;
  localparam logic [1:0] ERR_RANGE    = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tdc_ctrl.sv
// TDC measurement sequencer: clear/arm, wait for trigger, settle,
// double-sample with retry, range check, and hand off the result.
module tdc_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int CLR_CYC    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 4096,
  parameter int MIN_CNT    = 1,
  parameter int MAX_CNT    = 1000,
  parameter int MAX_RETRY  = 3
) (
  input  logic             rxclk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic             widen_flag,
  input  logic [CNT_W-1:0] tdc_num,
  output logic             tdc_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic [1:0]       res_err,
  output logic             busy,
  output logic [15:0]      meas_cnt
);

  localparam int CYC_MAX = max3(CLR_CYC, SETTLE_CYC, TIMEOUT);
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  state_t             state_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [1:0]         retry_q;
  logic [1:0]         retry_d;
  logic               ph_q;
  logic [CNT_W-1:0]   s0_q;
  logic               tdc_en_q;
  logic               res_valid_q;
  logic [CNT_W-1:0]   res_data_q;
  logic [1:0]         res_err_q;
  logic [15:0]        meas_cnt_q;
  logic               widen_s;
  logic               in_range;

  sync_2ff u_sync (
    .clk_i (rxclk),
    .rst_i (rst),
    .d_i   (widen_flag),
    .q_o   (widen_s)
  );

  assign retry_d  = retry_q + 2'd1;
  assign in_range = (s0_q >= CNT_W'(MIN_CNT))
                 && (s0_q <= CNT_W'(MAX_CNT));

  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      retry_q     <= '0;
      ph_q        <= 1'b0;
      s0_q        <= '0;
      tdc_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= ERR_OK;
      meas_cnt_q  <= '0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      retry_q     <= '0;
      ph_q        <= 1'b0;
      tdc_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tdc_en_q <= 1'b0;
          cyc_q    <= '0;
          if (start) state_q <= ST_ARM;
        end
        ST_ARM: begin
          if (cyc_q == CYC_W'(CLR_CYC - 1)) begin
            state_q  <= ST_WAIT;
            cyc_q    <= '0;
            tdc_en_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        // A flag already high here is fresh: ARM cleared the front end.
        ST_WAIT: begin
          if (widen_s) begin
            state_q <= ST_SETTLE;
            cyc_q   <= '0;
          end else if (cyc_q == CYC_W'(TIMEOUT - 1)) begin
            state_q    <= ST_OUT;
            cyc_q      <= '0;
            tdc_en_q   <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= ERR_TIMEOUT;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
            state_q <= ST_SAMPLE;
            cyc_q   <= '0;
            ph_q    <= 1'b0;
            retry_q <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (!ph_q) begin
            s0_q <= tdc_num;
            ph_q <= 1'b1;
          end else begin
            ph_q <= 1'b0;
            if (tdc_num == s0_q) begin
              state_q <= ST_CHECK;
            end else if (retry_d == 2'(MAX_RETRY)) begin
              state_q    <= ST_OUT;
              retry_q    <= retry_d;
              tdc_en_q   <= 1'b0;
              res_data_q <= tdc_num;
              res_err_q  <= ERR_UNSTABLE;
            end else begin
              retry_q <= retry_d;
            end
          end
        end
        ST_CHECK: begin
          state_q    <= ST_OUT;
          tdc_en_q   <= 1'b0;
          res_data_q <= s0_q;
          res_err_q  <= in_range ? ERR_OK : ERR_RANGE;
        end
        // Valid rises one cycle after entry so data is already stable.
        ST_OUT: begin
          tdc_en_q <= 1'b0;
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            meas_cnt_q  <= meas_cnt_q + 16'd1;
            retry_q     <= '0;
            cyc_q       <= '0;
            state_q     <= cont ? ST_ARM : ST_IDLE;
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          tdc_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign tdc_en    = tdc_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign meas_cnt  = meas_cnt_q;

endmodule
